al_param_seq: RTL and testbench



---
 rtl/al_param_seq_if.sv | 26 ++
 rtl/al_param_seq.sv | 113 +++++++++++
 tb/tb_al_param_seq.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/al_param_seq_if.sv
// al_param_seq_if: flash, target and status signals of the auto-load sequencer
interface al_param_seq_if #(
  parameter int NTGT = 4
);
  logic START;
  logic [15:0] BPI_RD_DATA;
  logic BPI_RD_VALID;
  logic [NTGT-1:0] TGT_DONE;
  logic BPI_RD_REQ;
  logic [11:0] BPI_AL_REG;
  logic [NTGT-1:0] CAPTURE;
  logic CLR_AL_DONE;
  logic AL_BUSY;
  logic AL_DONE;
  logic AL_ERR;
  logic [1:0] AL_ERR_CODE;
  logic [2:0] AL_ERR_IDX;
  modport master (
    output START, BPI_RD_DATA, BPI_RD_VALID, TGT_DONE,
    input BPI_RD_REQ, BPI_AL_REG, CAPTURE, CLR_AL_DONE, AL_BUSY, AL_DONE, AL_ERR, AL_ERR_CODE, AL_ERR_IDX
  );
  modport slave (
    input START, BPI_RD_DATA, BPI_RD_VALID, TGT_DONE,
    output BPI_RD_REQ, BPI_AL_REG, CAPTURE, CLR_AL_DONE, AL_BUSY, AL_DONE, AL_ERR, AL_ERR_CODE, AL_ERR_IDX
  );
endinterface

// File: rtl/al_param_seq.sv
// al_param_seq: walks flash words into NTGT targets with timeouts and first-error capture
module al_param_seq #(
  parameter int NTGT = 4,
  parameter int TMO_CYC = 4095,
  parameter bit TMR = 0
) (
  input logic CLK40,
  input logic RST,
  al_param_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, CAPT, WAIT_DONE, CLR, FINISH} state_t;
  typedef struct packed {
    state_t st;
    logic [2:0] idx;
    logic [11:0] tim;
    logic done;
    logic err;
    logic [1:0] code;
    logic [2:0] eidx;
  } regs_t;
  localparam int NR = TMR ? 3 : 1;
  localparam logic [11:0] TMO = 12'(TMO_CYC);
  localparam logic [2:0] LAST = 3'(NTGT - 1);
  regs_t q [NR];
  regs_t r, d;
  logic [11:0] al_reg;
  logic [NTGT-1:0] sel;
  logic [11:0] tinc;
  logic hit, tag_ok, tmo, ld, err_ev;
  logic [1:0] err_c;
  if (TMR) begin : g_tmr
    assign r = regs_t'((q[0] & q[1]) | (q[0] & q[2]) | (q[1] & q[2]));
  end else begin : g_one
    assign r = q[0];
  end
  assign sel = NTGT'(1) << r.idx;
  assign hit = |(bus.TGT_DONE & sel);
  assign tag_ok = bus.BPI_RD_DATA[15:12] == {1'b0, r.idx};
  assign tinc = r.tim >= TMO ? TMO : r.tim + 12'd1;
  assign tmo = tinc == TMO;
  // state register copies (voted when TMR) and the held value register
  always_ff @(posedge CLK40 or posedge RST)
    if (RST) begin
      for (int k = 0; k < NR; k++) q[k] <= '0;
      al_reg <= '0;
    end else begin
      for (int k = 0; k < NR; k++) q[k] <= d;
      if (ld) al_reg <= bus.BPI_RD_DATA[11:0];
    end
  // next state, timer, index and first-error bookkeeping
  always_comb begin
    d = r;
    ld = 1'b0;
    err_ev = 1'b0;
    err_c = 2'b00;
    case (r.st)
      IDLE: if (bus.START) begin
        d = '0;
        d.st = REQ;
      end
      REQ: begin
        d.tim = '0;
        d.st = WAIT_DATA;
      end
      WAIT_DATA: begin
        d.tim = tinc;
        if (bus.BPI_RD_VALID) begin
          ld = tag_ok;
          d.st = tag_ok ? CAPT : CLR;
          err_ev = !tag_ok;
          err_c = 2'b11;
        end else if (tmo) begin
          d.st = FINISH;
          err_ev = 1'b1;
          err_c = 2'b01;
        end
      end
      CAPT: begin
        d.tim = '0;
        d.st = WAIT_DONE;
      end
      WAIT_DONE: begin
        d.tim = tinc;
        if (hit) d.st = CLR;
        else if (tmo) begin
          d.st = CLR;
          err_ev = 1'b1;
          err_c = 2'b10;
        end
      end
      CLR: begin
        d.st = r.idx == LAST ? FINISH : REQ;
        d.idx = r.idx == LAST ? r.idx : r.idx + 3'd1;
      end
      default: d.st = IDLE;
    endcase
    if (err_ev && !r.err) begin
      d.err = 1'b1;
      d.code = err_c;
      d.eidx = r.idx;
    end
    if (d.st == FINISH) d.done = 1'b1;
  end
  assign bus.BPI_RD_REQ = r.st == REQ;
  assign bus.CAPTURE = r.st == CAPT ? sel : '0;
  assign bus.CLR_AL_DONE = r.st == CLR;
  assign bus.AL_BUSY = r.st != IDLE && r.st != FINISH;
  assign bus.AL_DONE = r.done;
  assign bus.AL_ERR = r.err;
  assign bus.AL_ERR_CODE = r.code;
  assign bus.AL_ERR_IDX = r.eidx;
  assign bus.BPI_AL_REG = al_reg;
endmodule

// File: tb/tb_al_param_seq.sv
// tb_al_param_seq: flash/target responder with capture and clear scoreboards
`timescale 1ns/1ps
module tb_al_param_seq;
  localparam int NTGT = 4;
  typedef struct {int idx; int at;} cap_t;
  logic CLK40 = 1'b0;
  logic RST = 1'b1;
  int cyc = 0;
  int checks = 0, errors = 0;
  int req_cnt = 0, cap_cnt = 0, clr_cnt = 0, last_req_cyc = 0;
  int bad_idx = -1, nodata_idx = -1, nodone_idx = -1;
  int dly [NTGT];
  int rd_at = -1, rd_idx = 0, done_at = -1, done_idx = 0;
  int req_q [$];
  cap_t cap_q [$];
  int clr_q [$];
  al_param_seq_if #(.NTGT(NTGT)) bus ();
  al_param_seq #(.NTGT(NTGT), .TMO_CYC(4095), .TMR(0)) dut (.CLK40(CLK40), .RST(RST), .bus(bus));
  always #12.5 CLK40 = ~CLK40;
  always @(posedge CLK40) cyc <= cyc + 1;
  // responder and monitor: answers flash requests, raises target done, scores strobes
  initial begin
    cap_t e;
    int c;
    logic [NTGT+11:0] exp_cap;
    bus.BPI_RD_VALID = 1'b0;
    bus.BPI_RD_DATA = '0;
    bus.TGT_DONE = '0;
    forever begin
      @(negedge CLK40);
      bus.BPI_RD_VALID = 1'b0;
      if (RST) begin
        bus.TGT_DONE = '0;
        rd_at = -1;
        done_at = -1;
      end else begin
        if (bus.BPI_RD_REQ === 1'b1) begin
          req_cnt++;
          last_req_cyc = cyc;
          if (req_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_unexpected got BPI_RD_REQ=1 at cyc %0d want no request", cyc);
          end else begin
            rd_idx = req_q.pop_front();
            rd_at = rd_idx == nodata_idx ? -1 : cyc + 2;
          end
        end
        if (bus.CAPTURE !== '0) begin
          cap_cnt++;
          checks++;
          if (cap_q.size() == 0) begin
            errors++;
            $display("FAIL cap_unexpected got CAPTURE=%b at cyc %0d want none", bus.CAPTURE, cyc);
          end else begin
            e = cap_q.pop_front();
            exp_cap = {NTGT'(1) << e.idx, 12'h0A0 + 12'(e.idx)};
            if ({bus.CAPTURE, bus.BPI_AL_REG} !== exp_cap || cyc != e.at) begin
              errors++;
              $display("FAIL cap_seq got CAPTURE/AL_REG=%h at cyc %0d want %h at cyc %0d", {bus.CAPTURE, bus.BPI_AL_REG}, cyc, exp_cap, e.at);
            end
            clr_q.push_back(cyc + ((e.idx == nodone_idx || dly[e.idx] >= 4095) ? 4096 : dly[e.idx] + 1));
            if (e.idx == nodone_idx) bus.TGT_DONE = ~(NTGT'(1) << e.idx);
            else begin
              done_at = cyc + dly[e.idx];
              done_idx = e.idx;
            end
          end
        end
        if (bus.CLR_AL_DONE === 1'b1) begin
          clr_cnt++;
          bus.TGT_DONE = '0;
          done_at = -1;
          if (clr_q.size() > 0) begin
            checks++;
            c = clr_q.pop_front();
            if (cyc != c) begin
              errors++;
              $display("FAIL clr_timing got CLR_AL_DONE at cyc %0d want cyc %0d", cyc, c);
            end
          end
        end
        if (cyc == rd_at) begin
          bus.BPI_RD_VALID = 1'b1;
          bus.BPI_RD_DATA = rd_idx == bad_idx ? {4'(rd_idx + 1), 12'h123} : {4'(rd_idx), 12'h0A0 + 12'(rd_idx)};
          if (rd_idx != bad_idx) cap_q.push_back('{rd_idx, cyc + 1});
        end
        if (cyc == done_at) bus.TGT_DONE[done_idx] = 1'b1;
      end
    end
  end
  task automatic start_run();
    req_q.delete();
    cap_q.delete();
    clr_q.delete();
    req_cnt = 0;
    cap_cnt = 0;
    clr_cnt = 0;
    for (int i = 0; i < NTGT; i++) req_q.push_back(i);
    @(negedge CLK40);
    bus.START = 1'b1;
    @(negedge CLK40);
    bus.START = 1'b0;
  endtask
  task automatic wait_done(output int fc);
    int n = 0;
    while (bus.AL_DONE !== 1'b1 && n < 30000) begin
      @(negedge CLK40);
      n++;
    end
    fc = cyc;
    checks++;
    if (n >= 30000) begin
      errors++;
      $display("FAIL run_timeout got AL_DONE=%b after %0d cycles want 1", bus.AL_DONE, n);
    end
  endtask
  task automatic wait_caps(input int k);
    int n = 0;
    while (cap_cnt < k && n < 20000) begin
      @(negedge CLK40);
      n++;
    end
    checks++;
    if (n >= 20000) begin
      errors++;
      $display("FAIL cap_wait got %0d captures want %0d", cap_cnt, k);
    end
  endtask
  task automatic test_reset();
    checks++;
    if ({bus.BPI_RD_REQ, bus.CAPTURE, bus.CLR_AL_DONE} !== '0) begin
      errors++;
      $display("FAIL reset_strobes got %b want 0", {bus.BPI_RD_REQ, bus.CAPTURE, bus.CLR_AL_DONE});
    end
    checks++;
    if ({bus.AL_BUSY, bus.AL_DONE, bus.AL_ERR, bus.AL_ERR_CODE, bus.AL_ERR_IDX, bus.BPI_AL_REG} !== '0) begin
      errors++;
      $display("FAIL reset_status got %h want 0", {bus.AL_BUSY, bus.AL_DONE, bus.AL_ERR, bus.AL_ERR_CODE, bus.AL_ERR_IDX, bus.BPI_AL_REG});
    end
    RST = 1'b0;
    repeat (4) @(negedge CLK40);
    checks++;
    if (bus.AL_BUSY !== 1'b0 || req_cnt != 0) begin
      errors++;
      $display("FAIL idle_no_start got busy=%b reqs=%0d want 0 0", bus.AL_BUSY, req_cnt);
    end
  endtask
  task automatic test_nominal();
    int fc;
    start_run();
    checks++;
    if (bus.BPI_RD_REQ !== 1'b1 || bus.AL_BUSY !== 1'b1) begin
      errors++;
      $display("FAIL start_latency got req=%b busy=%b want 1 1", bus.BPI_RD_REQ, bus.AL_BUSY);
    end
    wait_done(fc);
    checks++;
    if (req_cnt != 4 || cap_cnt != 4 || clr_cnt != 4) begin
      errors++;
      $display("FAIL nom_counts got req=%0d cap=%0d clr=%0d want 4 4 4", req_cnt, cap_cnt, clr_cnt);
    end
    checks++;
    if (bus.BPI_AL_REG !== 12'h0A3 || bus.AL_ERR !== 1'b0 || bus.AL_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL nom_final got reg=%h err=%b busy=%b want 0a3 0 0", bus.BPI_AL_REG, bus.AL_ERR, bus.AL_BUSY);
    end
    repeat (3) @(negedge CLK40);
    checks++;
    if (bus.AL_DONE !== 1'b1 || bus.BPI_AL_REG !== 12'h0A3 || cap_q.size() != 0) begin
      errors++;
      $display("FAIL nom_hold got done=%b reg=%h pending=%0d want 1 0a3 0", bus.AL_DONE, bus.BPI_AL_REG, cap_q.size());
    end
  endtask
  task automatic test_tag_mismatch();
    int fc;
    bad_idx = 1;
    start_run();
    wait_done(fc);
    bad_idx = -1;
    checks++;
    if (req_cnt != 4 || cap_cnt != 3 || clr_cnt != 4) begin
      errors++;
      $display("FAIL tag_counts got req=%0d cap=%0d clr=%0d want 4 3 4", req_cnt, cap_cnt, clr_cnt);
    end
    checks++;
    if ({bus.AL_ERR, bus.AL_ERR_CODE, bus.AL_ERR_IDX} !== {1'b1, 2'b11, 3'd1} || bus.BPI_AL_REG !== 12'h0A3) begin
      errors++;
      $display("FAIL tag_err got err=%b code=%b idx=%0d reg=%h want 1 11 1 0a3", bus.AL_ERR, bus.AL_ERR_CODE, bus.AL_ERR_IDX, bus.BPI_AL_REG);
    end
  endtask
  task automatic test_done_timeout();
    int fc;
    nodone_idx = 2;
    start_run();
    wait_done(fc);
    nodone_idx = -1;
    checks++;
    if (cap_cnt != 4 || clr_cnt != 4 || clr_q.size() != 0) begin
      errors++;
      $display("FAIL dtmo_counts got cap=%0d clr=%0d pending=%0d want 4 4 0", cap_cnt, clr_cnt, clr_q.size());
    end
    checks++;
    if ({bus.AL_DONE, bus.AL_ERR, bus.AL_ERR_CODE, bus.AL_ERR_IDX} !== {1'b1, 1'b1, 2'b10, 3'd2}) begin
      errors++;
      $display("FAIL dtmo_err got done=%b err=%b code=%b idx=%0d want 1 1 10 2", bus.AL_DONE, bus.AL_ERR, bus.AL_ERR_CODE, bus.AL_ERR_IDX);
    end
  endtask
  task automatic test_data_timeout();
    int fc;
    nodata_idx = 0;
    start_run();
    wait_done(fc);
    nodata_idx = -1;
    checks++;
    if (fc != last_req_cyc + 4096) begin
      errors++;
      $display("FAIL data_tmo_time got finish at %0d want %0d", fc, last_req_cyc + 4096);
    end
    checks++;
    if (req_cnt != 1 || cap_cnt != 0 || clr_cnt != 0) begin
      errors++;
      $display("FAIL data_tmo_counts got req=%0d cap=%0d clr=%0d want 1 0 0", req_cnt, cap_cnt, clr_cnt);
    end
    checks++;
    if ({bus.AL_DONE, bus.AL_ERR, bus.AL_ERR_CODE, bus.AL_ERR_IDX} !== {1'b1, 1'b1, 2'b01, 3'd0} || bus.BPI_AL_REG !== 12'h0A3) begin
      errors++;
      $display("FAIL data_tmo_err got done=%b err=%b code=%b idx=%0d reg=%h want 1 1 01 0 0a3", bus.AL_DONE, bus.AL_ERR, bus.AL_ERR_CODE, bus.AL_ERR_IDX, bus.BPI_AL_REG);
    end
  endtask
  task automatic test_back_to_back();
    int fc;
    dly[0] = 4095;
    start_run();
    wait_caps(2);
    repeat (10) @(negedge CLK40);
    bus.START = 1'b1;
    @(negedge CLK40);
    bus.START = 1'b0;
    wait_done(fc);
    dly[0] = 700;
    checks++;
    if (bus.AL_ERR !== 1'b0 || bus.AL_ERR_CODE !== 2'b00) begin
      errors++;
      $display("FAIL simul_err got err=%b code=%b want 0 00", bus.AL_ERR, bus.AL_ERR_CODE);
    end
    checks++;
    if (req_cnt != 4 || cap_cnt != 4 || clr_cnt != 4) begin
      errors++;
      $display("FAIL start_ignored got req=%0d cap=%0d clr=%0d want 4 4 4", req_cnt, cap_cnt, clr_cnt);
    end
  endtask
  task automatic test_reset_mid();
    int fc;
    start_run();
    wait_caps(2);
    repeat (5) @(negedge CLK40);
    RST = 1'b1;
    #1;
    checks++;
    if ({bus.BPI_RD_REQ, bus.CAPTURE, bus.CLR_AL_DONE, bus.AL_BUSY, bus.AL_DONE, bus.AL_ERR, bus.AL_ERR_CODE, bus.AL_ERR_IDX, bus.BPI_AL_REG} !== '0) begin
      errors++;
      $display("FAIL rst_mid got %h want 0", {bus.BPI_RD_REQ, bus.CAPTURE, bus.CLR_AL_DONE, bus.AL_BUSY, bus.AL_DONE, bus.AL_ERR, bus.AL_ERR_CODE, bus.AL_ERR_IDX, bus.BPI_AL_REG});
    end
    repeat (2) @(negedge CLK40);
    RST = 1'b0;
    checks++;
    if (cap_cnt != 2 || clr_cnt != 1) begin
      errors++;
      $display("FAIL rst_no_strobe got cap=%0d clr=%0d want 2 1", cap_cnt, clr_cnt);
    end
    start_run();
    checks++;
    if (bus.BPI_RD_REQ !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart got req=%b want 1", bus.BPI_RD_REQ);
    end
    wait_done(fc);
    checks++;
    if (cap_cnt != 4 || bus.BPI_AL_REG !== 12'h0A3 || bus.AL_ERR !== 1'b0) begin
      errors++;
      $display("FAIL rst_rerun got cap=%0d reg=%h err=%b want 4 0a3 0", cap_cnt, bus.BPI_AL_REG, bus.AL_ERR);
    end
  endtask
  initial begin
    bus.START = 1'b0;
    for (int i = 0; i < NTGT; i++) dly[i] = 700;
    repeat (3) @(negedge CLK40);
    test_reset();
    test_nominal();
    test_tag_mismatch();
    test_done_timeout();
    test_data_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
